sfp_status_filter: RTL and testbench

SFP_STATUS_FILTER -- requirements
Module: sfp_status_filter

---
 rtl/sfp_pkg.sv | 38 +++
 rtl/sfp_bit_filter.sv | 88 ++++++++
 rtl/sfp_status_filter.sv | 98 +++++++++
 tb/tb_sfp_status_filter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared constants and helpers for the SFP status filter.
// Holds the default sizing, the evt bit offsets and the clog2 helper.
package sfp_pkg;

   localparam int unsigned DEFAULT_NCH    = 8;
   localparam int unsigned DEFAULT_STABLE = 3;

   // evt layout: mod_abs bits at the bottom, LOS bits directly above them
   localparam int unsigned MOD_ABS_OFS = 0;
   localparam int unsigned LOS_OFS     = DEFAULT_NCH;

   // Per-tick action taken by one bit filter
   typedef enum logic [1:0] {
      ActHold,
      ActLoad,
      ActCount,
      ActCommit
   } filt_act_e;

   // Ceiling log2, minimum result 1 so counters never collapse to zero width
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   // LOS offset for an arbitrary cage count
   function automatic int unsigned los_ofs(input int unsigned nch);
      return nch;
   endfunction

endpackage

// File: rtl/sfp_bit_filter.sv
// One-bit SFP status filter: 2-flop synchronizer, candidate bit, stability counter
// and filtered status. The status only follows a value held for STABLE further ticks.
module sfp_bit_filter
   import sfp_pkg::*;
#(
   parameter int unsigned STABLE  = DEFAULT_STABLE,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_pin,
   output logic o_status
);

   localparam int unsigned       CntW   = clog2(STABLE + 1);
   localparam logic [CntW-1:0]   CntMax = CntW'(STABLE - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_cand;
   logic [CntW-1:0] r_cnt;
   logic            r_status;

   logic            w_cand_nxt;
   logic [CntW-1:0] w_cnt_nxt;
   logic            w_status_nxt;
   filt_act_e       w_act;

   // Synchronizer runs every clk, independent of tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= RST_VAL;
         r_sync2 <= RST_VAL;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
      end
   end

   // Decide the tick action and the resulting next state
   always_comb begin
      w_act        = ActHold;
      w_cand_nxt   = r_cand;
      w_cnt_nxt    = r_cnt;
      w_status_nxt = r_status;
      if (i_tick) begin
         if (r_sync2 != r_cand) begin
            w_act = ActLoad;
         end else if (r_cnt < CntMax) begin
            w_act = ActCount;
         end else begin
            w_act = ActCommit;
         end
      end
      unique case (w_act)
         ActLoad: begin
            w_cand_nxt = r_sync2;
            w_cnt_nxt  = '0;
         end
         ActCount: begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
         ActCommit: begin
            // Counter saturates at CntMax; status keeps tracking the candidate
            w_status_nxt = r_cand;
         end
         default: begin
         end
      endcase
   end

   // Filter state register; reset discards any partial count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand   <= RST_VAL;
         r_cnt    <= '0;
         r_status <= RST_VAL;
      end else begin
         r_cand   <= w_cand_nxt;
         r_cnt    <= w_cnt_nxt;
         r_status <= w_status_nxt;
      end
   end

   assign o_status = r_status;

endmodule

// File: rtl/sfp_status_filter.sv
// SFP cage status filter: debounces mod_abs and LOS pins per cage on a slow tick.
// Optional sticky change flags and level interrupt are built only when
// SFP_FILT_IRQ_EN is defined; otherwise evt and irq are tied to zero.
module sfp_status_filter
   import sfp_pkg::*;
#(
   parameter int unsigned       NCH     = DEFAULT_NCH,
   parameter int unsigned       STABLE  = DEFAULT_STABLE,
   parameter logic [2*NCH-1:0]  RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [NCH-1:0]   mod_abs_pin,
   input  logic [NCH-1:0]   los_pin,
   output logic [NCH-1:0]   mod_abs_reg,
   output logic [NCH-1:0]   los_reg,
   output logic [2*NCH-1:0] evt,
   input  logic [2*NCH-1:0] evt_clr,
   input  logic [2*NCH-1:0] irq_mask,
   output logic             irq
);

   localparam int unsigned LosOfs = los_ofs(NCH);

   logic [2*NCH-1:0] w_status;

   for (genvar i = 0; i < NCH; i++) begin : g_cage
      sfp_bit_filter #(
         .STABLE  (STABLE),
         .RST_VAL (RST_VAL[MOD_ABS_OFS + i])
      ) u_mod_abs (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_tick   (tick),
         .i_pin    (mod_abs_pin[i]),
         .o_status (w_status[MOD_ABS_OFS + i])
      );

      sfp_bit_filter #(
         .STABLE  (STABLE),
         .RST_VAL (RST_VAL[LosOfs + i])
      ) u_los (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_tick   (tick),
         .i_pin    (los_pin[i]),
         .o_status (w_status[LosOfs + i])
      );
   end

   assign mod_abs_reg = w_status[MOD_ABS_OFS +: NCH];
   assign los_reg     = w_status[LosOfs +: NCH];

`ifdef SFP_FILT_IRQ_EN
   logic [2*NCH-1:0] r_status_prev;
   logic [2*NCH-1:0] r_evt;
   logic             r_irq;
   logic [2*NCH-1:0] w_set;
   logic [2*NCH-1:0] w_evt_nxt;

   // Delayed status copy; resets to RST_VAL so reset release raises no event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status_prev <= RST_VAL;
      end else begin
         r_status_prev <= w_status;
      end
   end

   // Sticky flags: a new change beats a coincident clear
   always_comb begin
      w_set     = w_status ^ r_status_prev;
      w_evt_nxt = (r_evt & ~evt_clr) | w_set;
   end

   // Event and interrupt registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evt <= '0;
         r_irq <= 1'b0;
      end else begin
         r_evt <= w_evt_nxt;
         r_irq <= |(r_evt & ~irq_mask);
      end
   end

   assign evt = r_evt;
   assign irq = r_irq;
`else
   logic w_unused;

   assign w_unused = ^{evt_clr, irq_mask};
   assign evt      = '0;
   assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_sfp_status_filter.sv
// Directed bench for sfp_status_filter (NCH=8, STABLE=3, RST_VAL all ones).
// Event/irq expectations follow SFP_FILT_IRQ_EN; without it they must stay zero.
module tb_sfp_status_filter;

   localparam int unsigned NCH = 8;
`ifdef SFP_FILT_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tick;
   logic [NCH-1:0]   mod_abs_pin;
   logic [NCH-1:0]   los_pin;
   logic [NCH-1:0]   mod_abs_reg;
   logic [NCH-1:0]   los_reg;
   logic [2*NCH-1:0] evt;
   logic [2*NCH-1:0] evt_clr;
   logic [2*NCH-1:0] irq_mask;
   logic             irq;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sfp_status_filter #(
      .NCH     (NCH),
      .STABLE  (3),
      .RST_VAL ('1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .mod_abs_pin (mod_abs_pin),
      .los_pin     (los_pin),
      .mod_abs_reg (mod_abs_reg),
      .los_reg     (los_reg),
      .evt         (evt),
      .evt_clr     (evt_clr),
      .irq_mask    (irq_mask),
      .irq         (irq)
   );

   function automatic logic [15:0] ev(input logic [15:0] x);
      return IrqEn ? x : 16'h0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clk step, leaving time just after the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Nine idle clks then a one-clk tick; returns 1 ns after the tick edge
   task automatic do_tick();
      repeat (9) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      tick        = 1'b0;
      mod_abs_pin = '0;
      los_pin     = '0;
      evt_clr     = '0;
      irq_mask    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mod", mod_abs_reg, 8'hFF);
      check("rst_los", los_reg, 8'hFF);
      check("rst_evt", evt, 16'h0000);
      check("rst_irq", irq, 1'b0);
      rst_n = 1'b1;

      // Pins low: candidate loads on tick 1, status drops on tick 4
      do_tick();
      check("t1_mod", mod_abs_reg, 8'hFF);
      check("t1_evt", evt, 16'h0000);
      do_tick();
      check("t2_mod", mod_abs_reg, 8'hFF);
      do_tick();
      check("t3_mod", mod_abs_reg, 8'hFF);
      check("t3_los", los_reg, 8'hFF);
      do_tick();
      check("t4_mod", mod_abs_reg, 8'h00);
      check("t4_los", los_reg, 8'h00);
      check("t4_evt_early", evt, 16'h0000);
      step();
      check("t4_evt", evt, ev(16'hFFFF));
      check("t4_irq_early", irq, 1'b0);
      step();
      check("t4_irq", irq, IrqEn);

      // Clear all flags; irq follows one clk later
      evt_clr = 16'hFFFF;
      step();
      evt_clr = '0;
      check("clr_evt", evt, 16'h0000);
      check("clr_irq_hold", irq, IrqEn);
      step();
      check("clr_irq", irq, 1'b0);

      // Two-tick glitch on los_pin[2] never reaches status
      los_pin[2] = 1'b1;
      do_tick();
      do_tick();
      check("gl_los_a", los_reg, 8'h00);
      los_pin[2] = 1'b0;
      for (int k = 0; k < 4; k++) do_tick();
      check("gl_los_b", los_reg, 8'h00);
      step();
      check("gl_evt", evt, 16'h0000);

      // Stable los_pin[2]: set coincides with clear, set wins
      los_pin[2] = 1'b1;
      do_tick();
      do_tick();
      do_tick();
      check("los2_t3", los_reg, 8'h00);
      do_tick();
      check("los2_t4", los_reg, 8'h04);
      evt_clr[10] = 1'b1;
      step();
      evt_clr = '0;
      check("los2_evt_setwins", evt, ev(16'h0400));
      step();
      check("los2_irq", irq, IrqEn);
      evt_clr[10] = 1'b1;
      step();
      evt_clr = '0;
      check("los2_evt_clr", evt, 16'h0000);
      check("los2_irq_hold", irq, IrqEn);
      step();
      check("los2_irq_drop", irq, 1'b0);

      // Fully masked: flag sets but irq stays low until unmasked
      irq_mask       = 16'hFFFF;
      mod_abs_pin[0] = 1'b1;
      do_tick();
      do_tick();
      do_tick();
      check("m0_t3", mod_abs_reg, 8'h00);
      do_tick();
      check("m0_t4", mod_abs_reg, 8'h01);
      step();
      check("m0_evt", evt, ev(16'h0001));
      step();
      check("m0_irq_masked_a", irq, 1'b0);
      step();
      check("m0_irq_masked_b", irq, 1'b0);
      irq_mask = '0;
      step();
      check("m0_irq_unmasked", irq, IrqEn);
      evt_clr = 16'h0001;
      step();
      evt_clr = '0;
      step();
      check("m0_irq_cleared", irq, 1'b0);

      // Reset after load + 2 matching ticks discards the partial count
      mod_abs_pin = 8'h03;
      do_tick();
      do_tick();
      do_tick();
      check("mr_pre", mod_abs_reg, 8'h01);
      rst_n = 1'b0;
      #1;
      check("mr_rst_mod", mod_abs_reg, 8'hFF);
      check("mr_rst_los", los_reg, 8'hFF);
      check("mr_rst_evt", evt, 16'h0000);
      check("mr_rst_irq", irq, 1'b0);
      step();
      rst_n = 1'b1;
      do_tick();
      check("mr_t1_mod", mod_abs_reg, 8'hFF);
      check("mr_t1_evt", evt, 16'h0000);
      do_tick();
      do_tick();
      check("mr_t3_mod", mod_abs_reg, 8'hFF);
      check("mr_t3_los", los_reg, 8'hFF);
      do_tick();
      check("mr_t4_mod", mod_abs_reg, 8'h03);
      check("mr_t4_los", los_reg, 8'h04);
      step();
      check("mr_evt", evt, ev(16'hFBFC));
      step();
      check("mr_irq", irq, IrqEn);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
